// File: rtl/regfile_ctrl.sv
// 32x32 register-file controller over a dual-port RAM: power-up clear, two-port
// reads with one-entry write buffer and forwarding, x0 hard-wired to zero.
module regfile_ctrl #(
  parameter logic BANK         = 1'b0,
  parameter int   CLR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rf_ready,
  input  logic        rd_req,
  input  logic [4:0]  rs1_adr,
  input  logic [4:0]  rs2_adr,
  output logic        rd_valid,
  output logic [31:0] rs1_dat,
  output logic [31:0] rs2_dat,
  input  logic        wr_en,
  input  logic [4:0]  wr_adr,
  input  logic [31:0] wr_dat,
  output logic        wr_rdy,
  output logic [5:0]  ram_ada,
  output logic [5:0]  ram_adb,
  output logic [31:0] ram_dina,
  output logic [31:0] ram_dinb,
  output logic        ram_cea,
  output logic        ram_ceb,
  output logic        ram_wrea,
  output logic        ram_wreb,
  output logic        ram_ocea,
  output logic        ram_oceb,
  input  logic [31:0] ram_douta,
  input  logic [31:0] ram_doutb
);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;
  localparam state_t RST_STATE = (CLR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t      state_q, state_d;
  logic [4:0]  clr_cnt_q, clr_cnt_d;
  logic        wb_v_q, wb_v_d;
  logic [4:0]  wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic        rd_valid_q, rd_valid_d;
  logic        fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic        zero1_q, zero1_d, zero2_q, zero2_d;
  logic [31:0] rs1_hold_q, rs1_hold_d, rs2_hold_q, rs2_hold_d;

  logic        idle_s, wr_keep_s;
  logic        a_ce_s, a_we_s, b_ce_s;
  logic [4:0]  a_idx_s;
  logic [31:0] a_din_s;
  logic [31:0] rs1_new_s, rs2_new_s;

  assign idle_s    = (state_q == S_IDLE);
  assign wr_rdy    = idle_s & ~(rd_req & wb_v_q);
  assign wr_keep_s = wr_en & wr_rdy & (wr_adr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_cnt_q == 5'd31) state_d = S_IDLE; else state_d = S_CLEAR;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  // Port A arbitration: read launch beats buffer drain beats direct write.
  always_comb begin
    a_idx_s = rs1_adr;
    a_din_s = 32'd0;
    a_ce_s  = 1'b0;
    a_we_s  = 1'b0;
    b_ce_s  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        a_idx_s = clr_cnt_q;
        a_ce_s  = 1'b1;
        a_we_s  = 1'b1;
      end
      S_IDLE: begin
        if (rd_req) begin
          a_ce_s = 1'b1;
          b_ce_s = 1'b1;
        end else if (wb_v_q) begin
          a_idx_s = wb_adr_q;
          a_din_s = wb_dat_q;
          a_ce_s  = 1'b1;
          a_we_s  = 1'b1;
        end else if (wr_keep_s) begin
          a_idx_s = wr_adr;
          a_din_s = wr_dat;
          a_ce_s  = 1'b1;
          a_we_s  = 1'b1;
        end else begin
          a_ce_s = 1'b0;
        end
      end
      default: a_ce_s = 1'b0;
    endcase
  end

  // Enables are forced low while reset is held so nothing reaches the RAM.
  assign rf_ready = idle_s;
  assign ram_ada  = {BANK, a_idx_s};
  assign ram_adb  = {BANK, rs2_adr};
  assign ram_dina = a_din_s;
  assign ram_dinb = 32'd0;
  assign ram_cea  = rst_n & a_ce_s;
  assign ram_ceb  = rst_n & b_ce_s;
  assign ram_wrea = rst_n & a_we_s;
  assign ram_wreb = 1'b0;
  assign ram_ocea = 1'b1;
  assign ram_oceb = 1'b1;

  assign rs1_new_s = zero1_q ? 32'd0 : (fwd1_q ? wb_dat_q : ram_douta);
  assign rs2_new_s = zero2_q ? 32'd0 : (fwd2_q ? wb_dat_q : ram_doutb);
  assign rd_valid  = rd_valid_q;
  assign rs1_dat   = rd_valid_q ? rs1_new_s : rs1_hold_q;
  assign rs2_dat   = rd_valid_q ? rs2_new_s : rs2_hold_q;

  always_comb begin
    clr_cnt_d  = (state_q == S_CLEAR) ? clr_cnt_q + 5'd1 : clr_cnt_q;
    wb_v_d     = wb_v_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_d   = wb_dat_q;
    if (idle_s && rd_req) begin
      if (!wb_v_q && wr_keep_s) begin
        wb_v_d   = 1'b1;
        wb_adr_d = wr_adr;
        wb_dat_d = wr_dat;
      end else begin
        wb_v_d = wb_v_q;
      end
    end else if (idle_s && wb_v_q) begin
      // Buffer drains this cycle; a concurrent write refills it.
      wb_v_d = wr_keep_s;
      if (wr_keep_s) begin
        wb_adr_d = wr_adr;
        wb_dat_d = wr_dat;
      end else begin
        wb_adr_d = wb_adr_q;
      end
    end else begin
      wb_v_d = wb_v_q;
    end
    rd_valid_d = idle_s & rd_req;
    fwd1_d     = wb_v_q & (wb_adr_q == rs1_adr);
    fwd2_d     = wb_v_q & (wb_adr_q == rs2_adr);
    zero1_d    = (rs1_adr == 5'd0);
    zero2_d    = (rs2_adr == 5'd0);
    rs1_hold_d = rd_valid_q ? rs1_new_s : rs1_hold_q;
    rs2_hold_d = rd_valid_q ? rs2_new_s : rs2_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q  <= 5'd0;
      wb_v_q     <= 1'b0;
      wb_adr_q   <= 5'd0;
      wb_dat_q   <= 32'd0;
      rd_valid_q <= 1'b0;
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
      zero1_q    <= 1'b0;
      zero2_q    <= 1'b0;
      rs1_hold_q <= 32'd0;
      rs2_hold_q <= 32'd0;
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      wb_v_q     <= wb_v_d;
      wb_adr_q   <= wb_adr_d;
      wb_dat_q   <= wb_dat_d;
      rd_valid_q <= rd_valid_d;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
      zero1_q    <= zero1_d;
      zero2_q    <= zero2_d;
      rs1_hold_q <= rs1_hold_d;
      rs2_hold_q <= rs2_hold_d;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural RAM, architectural register model,
// directed scenarios followed by randomized traffic.
module tb_regfile_ctrl;
  localparam logic BANK = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_ready, rd_req, rd_valid, wr_en, wr_rdy;
  logic [4:0]  rs1_adr, rs2_adr, wr_adr;
  logic [31:0] rs1_dat, rs2_dat, wr_dat;
  logic [5:0]  ram_ada, ram_adb;
  logic [31:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
  logic        ram_cea, ram_ceb, ram_wrea, ram_wreb, ram_ocea, ram_oceb;

  regfile_ctrl #(.BANK(BANK), .CLR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .rf_ready(rf_ready),
    .rd_req(rd_req), .rs1_adr(rs1_adr), .rs2_adr(rs2_adr),
    .rd_valid(rd_valid), .rs1_dat(rs1_dat), .rs2_dat(rs2_dat),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_rdy(wr_rdy),
    .ram_ada(ram_ada), .ram_adb(ram_adb), .ram_dina(ram_dina), .ram_dinb(ram_dinb),
    .ram_cea(ram_cea), .ram_ceb(ram_ceb), .ram_wrea(ram_wrea), .ram_wreb(ram_wreb),
    .ram_ocea(ram_ocea), .ram_oceb(ram_oceb),
    .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  // Synchronous dual-port RAM, read-first, filled with garbage on the first edge.
  logic [31:0] ram [64];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= $urandom;
      ram_init <= 1'b1;
    end else begin
      if (ram_cea) begin
        if (ram_wrea) ram[ram_ada] <= ram_dina;
        ram_douta <= ram[ram_ada];
      end
      if (ram_ceb) ram_doutb <= ram[ram_adb];
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] arch [32];
  bit          occ;
  bit          exp_v;
  logic [31:0] exp1, exp2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    occ = 1'b0; exp_v = 1'b0; exp1 = 32'd0; exp2 = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rd_req = 1'b1; wr_en = 1'b1; wr_adr = 5'd3; wr_dat = 32'h55;
    rs1_adr = 5'd1; rs2_adr = 5'd2;
    #1;
    chk("rst_rf_ready", {31'd0, rf_ready}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rs1_dat", rs1_dat, 32'd0);
    chk("rst_rs2_dat", rs2_dat, 32'd0);
    chk("rst_ram_cea", {31'd0, ram_cea}, 32'd0);
    chk("rst_ram_ceb", {31'd0, ram_ceb}, 32'd0);
    chk("rst_ram_wrea", {31'd0, ram_wrea}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Checks the first n clear writes; requests are held active to prove they are ignored.
  task automatic check_clear(input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      chk("clr_rf_ready", {31'd0, rf_ready}, 32'd0);
      chk("clr_wr_rdy", {31'd0, wr_rdy}, 32'd0);
      chk("clr_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("clr_we", {30'd0, ram_cea, ram_wrea}, 32'd3);
      chk("clr_ada", {26'd0, ram_ada}, {26'd0, BANK, i[4:0]});
      chk("clr_dina", ram_dina, 32'd0);
    end
  endtask

  task automatic step(input bit rd, input logic [4:0] a1, input logic [4:0] a2,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd);
    bit exp_rdy, keep;
    @(negedge clk);
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_v});
    chk("rs1_dat", rs1_dat, exp1);
    chk("rs2_dat", rs2_dat, exp2);
    rd_req = rd; rs1_adr = a1; rs2_adr = a2; wr_en = we; wr_adr = wa; wr_dat = wd;
    #1;
    chk("rf_ready", {31'd0, rf_ready}, 32'd1);
    exp_rdy = !(rd && occ);
    keep    = we && exp_rdy && (wa != 5'd0);
    chk("wr_rdy", {31'd0, wr_rdy}, {31'd0, exp_rdy});
    chk("ram_wrea", {31'd0, ram_wrea}, {31'd0, (!rd && (occ || keep))});
    if (rd) begin
      chk("rd_ce", {30'd0, ram_cea, ram_ceb}, 32'd3);
      chk("rd_ada", {26'd0, ram_ada}, {26'd0, BANK, a1});
      chk("rd_adb", {26'd0, ram_adb}, {26'd0, BANK, a2});
    end
    exp_v = rd;
    if (rd) begin
      exp1 = (a1 == 5'd0) ? 32'd0 : arch[a1];
      exp2 = (a2 == 5'd0) ? 32'd0 : arch[a2];
    end
    if (keep) arch[wa] = wd;
    occ = rd ? (occ || keep) : (occ && keep);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic readback();
    for (int r = 0; r < 32; r++) step(1'b1, r[4:0], 5'(31 - r), 1'b0, 5'd0, 32'd0);
    idle();
  endtask

  initial begin
    do_reset();
    check_clear(32);

    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    step(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0);
    idle();
    step(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 32'h00001234);
    step(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
    idle();
    step(1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 32'hAAAA0009);
    step(1'b1, 5'd9, 5'd2, 1'b1, 5'd10, 32'hBBBB000A);
    step(1'b1, 5'd1, 5'd9, 1'b1, 5'd10, 32'hBBBB000A);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd10, 32'hBBBB000A);
    step(1'b1, 5'd10, 5'd9, 1'b0, 5'd0, 32'd0);
    idle();
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    idle();

    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1, a2, wa;
      a1 = 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, 7));
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), a1, a2, 1'($urandom_range(0, 1)), wa, $urandom);
    end
    idle();
    idle();
    readback();

    // Buffered write lost and clear restarted by a reset landing mid-clear.
    step(1'b1, 5'd3, 5'd4, 1'b1, 5'd12, 32'hCAFE000C);
    do_reset();
    check_clear(11);
    do_reset();
    check_clear(32);
    readback();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
